// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 bus writer: FSM state codes, default timing, command codes
// and the 4-bit init nibble table.
package lcd_pkg;

  localparam logic [2:0] StPwrup = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StSetup = 3'd2;
  localparam logic [2:0] StPulse = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;
  localparam logic [2:0] StWait  = 3'd5;

  localparam int unsigned PwrupCycDef = 1_000_000;
  localparam int unsigned SetupCycDef = 4;
  localparam int unsigned EnCycDef    = 25;
  localparam int unsigned CmdCycDef   = 2_000;
  localparam int unsigned LongCycDef  = 82_000;
  localparam int unsigned FifoDepthDef = 16;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int unsigned InitLen = 4;

  // 4-bit wake-up sequence: 0x3, 0x3, 0x3, then 0x2 to switch the controller to nibble mode.
  function automatic logic [3:0] init_nibble(input logic [2:0] idx);
    return (idx == 3'd3) ? 4'h2 : 4'h3;
  endfunction

  // Clear and home (and their don't-care variants 0x00..0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data & ~(CMD_CLEAR | CMD_HOME)) == 8'h00);
  endfunction

endpackage

// File: rtl/lcd_sync_fifo.sv
// Synchronous FIFO buffering {rs,data} words; push ignored when full, pop ignored when empty.
module lcd_sync_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthCnt = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Power-of-2 depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_bus_writer.sv
// HD44780 bus write engine: buffers {rs,data} words and replays them with setup/EN/hold/exec wait.
// Define LCD_4BIT_EN for the 4-bit interface (nibble transfers plus the internal init sequence).
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC  = PwrupCycDef,
  parameter int unsigned SETUP_CYC  = SetupCycDef,
  parameter int unsigned EN_CYC     = EnCycDef,
  parameter int unsigned CMD_CYC    = CmdCycDef,
  parameter int unsigned LONG_CYC   = LongCycDef,
  parameter int unsigned FIFO_DEPTH = FifoDepthDef
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       idle,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       lcd_on
);

  localparam int unsigned CntMax = (PWRUP_CYC > LONG_CYC) ? PWRUP_CYC : LONG_CYC;
  localparam int unsigned CntW   = ($clog2(CntMax + 1) > 20) ? $clog2(CntMax + 1) : 20;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [8:0]      fifo_rdata;
  logic            cnt_done, wait_long;

  assign cnt_done = (cnt_q == '0);

`ifdef LCD_4BIT_EN
  logic [8:0] word_q, word_d;
  logic       lo_q, lo_d;
  logic       init_q, init_d;
  logic [2:0] init_idx_q, init_idx_d;
  logic       init_busy;

  assign init_busy = (init_idx_q < 3'(InitLen));
  assign wait_long = init_q || is_long_cmd(word_q[8], word_q[7:0]);
  assign idle      = (state_q == StIdle) && fifo_empty && !init_busy;
`else
  assign wait_long = is_long_cmd(rs_q, data_q);
  assign idle      = (state_q == StIdle) && fifo_empty;
`endif

  lcd_sync_fifo #(
    .W     (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({in_rs, in_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Power-up counts up from the reset value; every other state loads its length minus one and
  // counts down to zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
`ifdef LCD_4BIT_EN
    word_d     = word_q;
    lo_d       = lo_q;
    init_d     = init_q;
    init_idx_d = init_idx_q;
`endif
    case (state_q)
      StPwrup: begin
        if (cnt_q == CntW'(PWRUP_CYC - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
`ifdef LCD_4BIT_EN
        if (init_busy) begin
          rs_d       = 1'b0;
          data_d     = {init_nibble(init_idx_q), 4'h0};
          init_idx_d = init_idx_q + 1'b1;
          init_d     = 1'b1;
          lo_d       = 1'b1;
          state_d    = StSetup;
          cnt_d      = CntW'(SETUP_CYC - 1);
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_rdata;
          rs_d     = fifo_rdata[8];
          data_d   = {fifo_rdata[7:4], 4'h0};
          init_d   = 1'b0;
          lo_d     = 1'b0;
          state_d  = StSetup;
          cnt_d    = CntW'(SETUP_CYC - 1);
        end
`else
        if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          {rs_d, data_d} = fifo_rdata;
          state_d        = StSetup;
          cnt_d          = CntW'(SETUP_CYC - 1);
        end
`endif
      end
      StSetup: begin
        if (cnt_done) begin
          state_d = StPulse;
          cnt_d   = CntW'(EN_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPulse: begin
        if (cnt_done) begin
          state_d = StHold;
          cnt_d   = CntW'(EN_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_done) begin
`ifdef LCD_4BIT_EN
          // High nibble done: present the low nibble and run another setup/pulse/hold.
          if (!lo_q) begin
            lo_d    = 1'b1;
            data_d  = {word_q[3:0], 4'h0};
            state_d = StSetup;
            cnt_d   = CntW'(SETUP_CYC - 1);
          end else
`endif
          begin
            state_d = StWait;
            cnt_d   = wait_long ? CntW'(LONG_CYC - 1) : CntW'(CMD_CYC - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWait: begin
        if (cnt_done) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StPwrup;
        cnt_d   = '0;
      end
    endcase
    en_d = (state_d == StPulse);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StPwrup;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
`ifdef LCD_4BIT_EN
      word_q     <= '0;
      lo_q       <= 1'b0;
      init_q     <= 1'b0;
      init_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
`ifdef LCD_4BIT_EN
      word_q     <= word_d;
      lo_q       <= lo_d;
      init_q     <= init_d;
      init_idx_q <= init_idx_d;
`endif
    end
  end

  assign in_ready = !fifo_full;
  assign lcd_en   = en_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;

endmodule
